// File: rtl/tc_mem_pkg.sv
// Shared types and constants for the program-memory fetch arbiter.
package tc_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  // Lane index width: covers up to 8 bytes per instruction fetch.
  localparam int LANE_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

endpackage

// File: rtl/tc_byte_assembler.sv
// Packs bytes returned by the program memory into little-endian lanes and
// commits the completed word to a holding register.
module tc_byte_assembler
  import tc_mem_pkg::*;
#(
  parameter int INSN_BYTES = 4,
  localparam int FETCH_W = 8 * INSN_BYTES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cap_en,
  input  logic [LANE_W-1:0]  cap_lane,
  input  logic [7:0]         cap_byte,
  input  logic               commit,
  output logic [FETCH_W-1:0] word
);

  logic [FETCH_W-1:0] work;
  logic [FETCH_W-1:0] merged;

  always_comb begin
    merged = work;
    if (cap_en) begin
      for (int i = 0; i < INSN_BYTES; i++) begin
        if (cap_lane == LANE_W'(i)) merged[8*i +: 8] = cap_byte;
      end
    end
  end

  // Commit uses the merged value so the final byte lands in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work <= '0;
      word <= '0;
    end else begin
      if (cap_en) work <= merged;
      if (commit) word <= merged;
    end
  end

endmodule

// File: rtl/tc_program_fetch_arbiter.sv
// Arbitrates instruction-fetch and byte data reads onto one 8-bit program
// memory with 1-cycle registered read latency.
//
// state | meaning
// IDLE  | no transaction; grant a pending request (round-robin on conflict)
// ISSUE | drive base+counter to memory, one byte per cycle
// DRAIN | capture the final byte; response valid follows next cycle
module tc_program_fetch_arbiter
  import tc_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSN_BYTES = 4,
  localparam int FETCH_W = 8 * INSN_BYTES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_ack,
  output logic               fetch_valid,
  output logic [FETCH_W-1:0] fetch_data,
  input  logic               data_req,
  input  logic [ADDR_W-1:0]  data_addr,
  output logic               data_ack,
  output logic               data_valid,
  output logic [7:0]         data_rdata,
  output logic [ADDR_W-1:0]  mem_address,
  input  logic [7:0]         mem_out,
  output logic               busy
);

  arb_state_t        state;
  grant_t            last_grant;
  grant_t            cur_grant;
  logic [ADDR_W-1:0] base_addr;
  logic [LANE_W-1:0] counter;
  logic [LANE_W-1:0] lane_d;
  logic              issue_d;
  logic              grant_fetch;
  logic              grant_data;
  logic              last_issue;

  // Acks are combinational, so they are gated by reset to stay low in reset.
  always_comb begin
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    if (rst && state == IDLE) begin
      if (fetch_req && data_req) begin
        if (last_grant == GRANT_DATA) grant_fetch = 1'b1;
        else                          grant_data  = 1'b1;
      end else begin
        grant_fetch = fetch_req;
        grant_data  = data_req;
      end
    end
  end

  assign fetch_ack   = grant_fetch;
  assign data_ack    = grant_data;
  assign busy        = (state != IDLE);
  assign last_issue  = (cur_grant == GRANT_DATA) ||
                       (counter == LANE_W'(INSN_BYTES - 1));
  // Counter stops on the last issue, so DRAIN keeps the last address.
  assign mem_address = (state == IDLE) ? '0 : base_addr + ADDR_W'(counter);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_grant  <= GRANT_DATA;
      cur_grant   <= GRANT_FETCH;
      base_addr   <= '0;
      counter     <= '0;
      lane_d      <= '0;
      issue_d     <= 1'b0;
      fetch_valid <= 1'b0;
      data_valid  <= 1'b0;
      data_rdata  <= '0;
    end else begin
      fetch_valid <= 1'b0;
      data_valid  <= 1'b0;
      issue_d     <= (state == ISSUE) && (cur_grant == GRANT_FETCH);
      lane_d      <= counter;
      case (state)
        IDLE: begin
          if (grant_fetch) begin
            cur_grant  <= GRANT_FETCH;
            last_grant <= GRANT_FETCH;
            base_addr  <= fetch_addr;
            counter    <= '0;
            state      <= ISSUE;
          end else if (grant_data) begin
            cur_grant  <= GRANT_DATA;
            last_grant <= GRANT_DATA;
            base_addr  <= data_addr;
            counter    <= '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (last_issue) state <= DRAIN;
          else            counter <= counter + 1'b1;
        end
        DRAIN: begin
          state <= IDLE;
          if (cur_grant == GRANT_FETCH) begin
            fetch_valid <= 1'b1;
          end else begin
            data_valid <= 1'b1;
            data_rdata <= mem_out;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  tc_byte_assembler #(
    .INSN_BYTES(INSN_BYTES)
  ) u_asm (
    .clk     (clk),
    .rst     (rst),
    .cap_en  (issue_d),
    .cap_lane(lane_d),
    .cap_byte(mem_out),
    .commit  ((state == DRAIN) && (cur_grant == GRANT_FETCH)),
    .word    (fetch_data)
  );

endmodule

// File: tb/tb_tc_program_fetch_arbiter.sv
// Self-checking bench: vector table plus hand-written arbitration and reset
// sequences, with responses checked against a scoreboard queue.
module tb_tc_program_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = '0;
  logic        fetch_ack;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        data_req = 1'b0;
  logic [15:0] data_addr = '0;
  logic        data_ack;
  logic        data_valid;
  logic [7:0]  data_rdata;
  logic [15:0] mem_address;
  logic [7:0]  mem_out = '0;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          at;
  } exp_t;

  typedef struct {
    bit          is_fetch;
    logic [15:0] addr;
    logic [31:0] exp;
  } vec_t;

  exp_t fq[$];
  exp_t dq[$];

  tc_program_fetch_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ack  (fetch_ack),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .data_req   (data_req),
    .data_addr  (data_addr),
    .data_ack   (data_ack),
    .data_valid (data_valid),
    .data_rdata (data_rdata),
    .mem_address(mem_address),
    .mem_out    (mem_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // 64K program memory with mem[i] = i[7:0], 1-cycle registered read.
  always @(posedge clk) mem_out <= mem_address[7:0];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({fetch_ack, fetch_valid, fetch_data, data_ack, data_valid,
                data_rdata, mem_address, busy});
  endfunction

  // Response monitor: pops the scoreboard whenever a valid pulses.
  always @(negedge clk) begin
    exp_t e;
    if (fetch_valid) begin
      if (fq.size() == 0) begin
        check("fetch_valid_unexpected", 64'(fetch_valid), 64'd0);
      end else begin
        e = fq.pop_front();
        check("fetch_data", 64'(fetch_data), 64'(e.data));
        check("fetch_valid_cycle", 64'(cyc), 64'(e.at));
      end
    end else if (fq.size() != 0 && cyc > fq[0].at) begin
      e = fq.pop_front();
      check("fetch_valid_missing", 64'(cyc), 64'(e.at));
    end
    if (data_valid) begin
      if (dq.size() == 0) begin
        check("data_valid_unexpected", 64'(data_valid), 64'd0);
      end else begin
        e = dq.pop_front();
        check("data_rdata", 64'(data_rdata), 64'(e.data));
        check("data_valid_cycle", 64'(cyc), 64'(e.at));
      end
    end else if (dq.size() != 0 && cyc > dq[0].at) begin
      e = dq.pop_front();
      check("data_valid_missing", 64'(cyc), 64'(e.at));
    end
  end

  task automatic run_vec(input vec_t v);
    int t;
    int lat;
    int nissue;
    exp_t e;
    lat    = v.is_fetch ? 6 : 3;
    nissue = v.is_fetch ? 4 : 1;
    next_cycle();
    if (v.is_fetch) begin fetch_req = 1'b1; fetch_addr = v.addr; end
    else            begin data_req  = 1'b1; data_addr  = v.addr; end
    t = cyc;
    sample();
    check("vec_acks", 64'({fetch_ack, data_ack}), v.is_fetch ? 64'd2 : 64'd1);
    e.data = v.exp;
    e.at   = t + lat;
    if (v.is_fetch) fq.push_back(e); else dq.push_back(e);
    for (int k = 1; k <= lat; k++) begin
      next_cycle();
      if (k == 1) begin fetch_req = 1'b0; data_req = 1'b0; end
      sample();
      if (k <= nissue) check("vec_mem_address", 64'(mem_address), 64'(16'(v.addr + 16'(k - 1))));
      check("vec_busy", 64'(busy), (k < lat) ? 64'd1 : 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int t;
    exp_t e;

    vecs[0] = '{1'b1, 16'h0010, 32'h1312_1110};
    vecs[1] = '{1'b0, 16'h0005, 32'h0000_0005};
    vecs[2] = '{1'b1, 16'hFFFE, 32'h0100_FFFE};
    vecs[3] = '{1'b0, 16'hFFFF, 32'h0000_00FF};
    vecs[4] = '{1'b1, 16'h1234, 32'h3736_3534};
    vecs[5] = '{1'b0, 16'h00AB, 32'h0000_00AB};
    vecs[6] = '{1'b1, 16'h0030, 32'h3332_3130};

    // Reset with random requests: everything stays at zero.
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      fetch_req  = 1'($urandom_range(0, 1));
      data_req   = 1'($urandom_range(0, 1));
      fetch_addr = 16'($urandom);
      data_addr  = 16'($urandom);
      sample();
      check("reset_outputs", all_outs(), 64'd0);
    end
    next_cycle();
    rst = 1'b1;
    fetch_req = 1'b0;
    data_req  = 1'b0;
    sample();
    check("idle_outputs", all_outs(), 64'd0);
    next_cycle();
    sample();
    check("idle_outputs2", all_outs(), 64'd0);

    // First conflict after reset goes to fetch; the held data request wins
    // the next conflict; the re-requested fetch is acked on the data valid cycle.
    next_cycle();
    fetch_req = 1'b1; fetch_addr = 16'h0020;
    data_req  = 1'b1; data_addr  = 16'h0040;
    t = cyc;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) next_cycle();
      if (k == 1) fetch_addr = 16'h0024;
      if (k == 7) data_req = 1'b0;
      sample();
      check("arb_fetch_ack", 64'(fetch_ack), (k == 0 || k == 9) ? 64'd1 : 64'd0);
      check("arb_data_ack", 64'(data_ack), (k == 6) ? 64'd1 : 64'd0);
      if (k == 0) begin e.data = 32'h2322_2120; e.at = t + 6; fq.push_back(e); end
      if (k == 6) begin e.data = 32'h0000_0040; e.at = t + 9; dq.push_back(e); end
      if (k == 9) begin e.data = 32'h2726_2524; e.at = t + 15; fq.push_back(e); end
    end
    next_cycle();
    fetch_req = 1'b0;
    for (int k = 0; k < 8; k++) next_cycle();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset in the middle of a fetch drops it with no response or residue.
    next_cycle();
    fetch_req = 1'b1; fetch_addr = 16'h0030;
    sample();
    check("mid_reset_ack", 64'(fetch_ack), 64'd1);
    next_cycle();
    fetch_req = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    sample();
    check("mid_reset_outputs", all_outs(), 64'd0);
    next_cycle();
    sample();
    check("mid_reset_outputs2", all_outs(), 64'd0);
    next_cycle();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sample();
      check("post_reset_quiet", 64'({fetch_valid, busy}), 64'd0);
      next_cycle();
    end
    run_vec(vecs[6]);

    for (int k = 0; k < 4; k++) next_cycle();
    check("scoreboard_drained", 64'(fq.size() + dq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
